uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter with a 16x oversampled bit clock.
//
// One byte can wait in a holding register while another frame is shifting out.
// A queued byte is loaded straight from the end of the stop period into the next
// start bit, so there are no idle cycles between frames.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit between
// the last data bit and the stop period.
//
// Parameters:
//   DBIT         data bits per frame (5..8)
//   SB_TICK      stop duration in s_tick units (16 = 1, 24 = 1.5, 32 = 2 stop bits)
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   s_tick       one-cycle enable at 16x the baud rate
//   tx_start     request to send din, honoured only while tx_ready is high
//   din          byte to send; din[DBIT-1:0] is used
//   tx_ready     holding register empty, a new byte can be accepted
//   tx_done_tick one-cycle pulse when a frame's stop period completes
//   tx           serial line, registered, idle high
module uart_tx #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_ready,
    output logic       tx_done_tick,
    output logic       tx
);

    // Wide enough for both the 16-tick bit period and the stop period.
    localparam int unsigned TickW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam logic [TickW-1:0] BitLast  = TickW'(15);
    localparam logic [TickW-1:0] StopLast = TickW'(SB_TICK - 1);
    localparam logic [2:0]       DataLast = 3'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e            state_q;
    logic [TickW-1:0]  tick_q;
    logic [2:0]        bit_q;
    logic [DBIT-1:0]   shift_q;
    logic [DBIT-1:0]   hold_q;
    logic              hold_full_q;
    logic              tx_q;
    logic              done_q;
`ifdef UART_TX_PARITY_EN
    logic              par_q;
`endif

    logic accept;
    assign accept       = tx_start && !hold_full_q;
    assign tx_ready     = !hold_full_q;
    assign tx_done_tick = done_q;
    assign tx           = tx_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                hold_q      <= din[DBIT-1:0];
                hold_full_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    // accept cannot coincide here: tx_ready is low while holding.
                    if (hold_full_q) begin
                        shift_q     <= hold_q;
`ifdef UART_TX_PARITY_EN
                        par_q       <= ^hold_q;
`endif
                        hold_full_q <= 1'b0;
                        tick_q      <= '0;
                        tx_q        <= 1'b0;
                        state_q     <= StStart;
                    end
                end
                StStart: begin
                    if (s_tick) begin
                        if (tick_q == BitLast) begin
                            tick_q  <= '0;
                            bit_q   <= '0;
                            tx_q    <= shift_q[0];
                            state_q <= StData;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                StData: begin
                    if (s_tick) begin
                        if (tick_q == BitLast) begin
                            tick_q  <= '0;
                            shift_q <= shift_q >> 1;
                            if (bit_q == DataLast) begin
`ifdef UART_TX_PARITY_EN
                                tx_q    <= par_q;
                                state_q <= StParity;
`else
                                tx_q    <= 1'b1;
                                state_q <= StStop;
`endif
                            end else begin
                                bit_q <= bit_q + 3'd1;
                                tx_q  <= shift_q[1];
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (s_tick) begin
                        if (tick_q == BitLast) begin
                            tick_q  <= '0;
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
`endif
                StStop: begin
                    if (s_tick) begin
                        if (tick_q == StopLast) begin
                            done_q <= 1'b1;
                            tick_q <= '0;
                            if (hold_full_q) begin
                                shift_q     <= hold_q;
`ifdef UART_TX_PARITY_EN
                                par_q       <= ^hold_q;
`endif
                                hold_full_q <= 1'b0;
                                tx_q        <= 1'b0;
                                state_q     <= StStart;
                            end else if (accept) begin
                                // Byte arriving on the final tick goes straight into
                                // the shifter so the next start bit is not delayed.
                                shift_q     <= din[DBIT-1:0];
`ifdef UART_TX_PARITY_EN
                                par_q       <= ^din[DBIT-1:0];
`endif
                                hold_full_q <= 1'b0;
                                tx_q        <= 1'b0;
                                state_q     <= StStart;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int DBIT_A = 8;
    localparam int SB_A   = 16;
    localparam int DBIT_B = 7;
    localparam int SB_B   = 32;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLEN_A = 16 + 16 * DBIT_A + SB_A + 16 * PAR;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_tick = 1'b0;
    logic       tx_start_a = 1'b0, tx_start_b = 1'b0;
    logic [7:0] din_a = 8'h00, din_b = 8'h00;
    logic       tx_ready_a, tx_done_tick_a, tx_a;
    logic       tx_ready_b, tx_done_tick_b, tx_b;

    int n_cmp = 0;
    int n_bad = 0;
    int ph = 0;
    int done_a = 0, done_b = 0;
    bit tick_fixed = 1'b1;
    bit tick_en = 1'b1;
    logic obs_a[$];
    logic obs_b[$];
    logic exp_q[$];

    uart_tx #(.DBIT(DBIT_A), .SB_TICK(SB_A)) dut_a (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start_a), .din(din_a),
        .tx_ready(tx_ready_a), .tx_done_tick(tx_done_tick_a), .tx(tx_a)
    );

    uart_tx #(.DBIT(DBIT_B), .SB_TICK(SB_B)) dut_b (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start_b), .din(din_b),
        .tx_ready(tx_ready_b), .tx_done_tick(tx_done_tick_b), .tx(tx_b)
    );

    always #5 clk = ~clk;

    // Tick source: every 4th clk in fixed mode, random gaps otherwise.
    initial begin : tickgen
        forever begin
            @(posedge clk);
            ph++;
            #1;
            s_tick = tick_en && (tick_fixed ? (ph % 4 == 0) : ($urandom_range(0, 3) == 0));
        end
    end

    // Line value seen by each s_tick, and done pulse counts.
    always @(negedge clk) begin
        if (s_tick) begin
            obs_a.push_back(tx_a);
            obs_b.push_back(tx_b);
        end
        if (tx_done_tick_a) done_a++;
        if (tx_done_tick_b) done_b++;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: line level for each s_tick of one frame.
    task automatic add_frame(input logic [7:0] b, input int dbit, input int sbt);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 16; i++) exp_q.push_back(1'b0);
        for (int i = 0; i < dbit; i++) begin
            for (int k = 0; k < 16; k++) exp_q.push_back(b[i]);
            p = p ^ b[i];
        end
        if (PAR != 0) for (int k = 0; k < 16; k++) exp_q.push_back(p);
        for (int i = 0; i < sbt; i++) exp_q.push_back(1'b1);
    endtask

    // Index of first disagreement between observed ticks and exp_q, -1 if none.
    function automatic int frame_diff(input bit use_b);
        logic o[$];
        if (use_b) o = obs_b;
        else o = obs_a;
        while (o.size() > 0 && o[0] === 1'b1) void'(o.pop_front());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= o.size()) return i;
            if (o[i] !== exp_q[i]) return i;
        end
        for (int i = exp_q.size(); i < o.size(); i++) if (o[i] !== 1'b1) return i;
        return -1;
    endfunction

    task automatic send_a(input logic [7:0] b);
        int k;
        k = 0;
        @(posedge clk); #2;
        while (!tx_ready_a && k < 20000) begin @(posedge clk); #2; k++; end
        tx_start_a = 1'b1; din_a = b;
        @(posedge clk); #2;
        tx_start_a = 1'b0; din_a = 8'($urandom);
    endtask

    task automatic send_b(input logic [7:0] b);
        int k;
        k = 0;
        @(posedge clk); #2;
        while (!tx_ready_b && k < 20000) begin @(posedge clk); #2; k++; end
        tx_start_b = 1'b1; din_b = b;
        @(posedge clk); #2;
        tx_start_b = 1'b0; din_b = 8'($urandom);
    endtask

    task automatic wait_done(input bit use_b, input int target);
        for (int k = 0; k < 30000; k++) begin
            if ((use_b ? done_b : done_a) >= target) break;
            @(negedge clk);
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic clear_obs();
        obs_a.delete(); obs_b.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; tx_start_a = 1'b1; din_a = 8'h55; tx_start_b = 1'b1; din_b = 8'h2A;
        repeat (3) @(posedge clk); #2;
        n_cmp += 4;
        if (tx_a !== 1'b1) begin n_bad++; $display("FAIL reset_tx_a: got %b want 1", tx_a); end
        if (tx_ready_a !== 1'b1) begin n_bad++; $display("FAIL reset_ready_a: got %b want 1", tx_ready_a); end
        if (tx_done_tick_a !== 1'b0) begin n_bad++; $display("FAIL reset_done_a: got %b want 0", tx_done_tick_a); end
        if (tx_b !== 1'b1) begin n_bad++; $display("FAIL reset_tx_b: got %b want 1", tx_b); end
        tx_start_a = 1'b0; tx_start_b = 1'b0; reset = 1'b0;
        repeat (100) @(posedge clk); #2;
        n_cmp += 2;
        if (tx_a !== 1'b1) begin n_bad++; $display("FAIL reset_start_ignored_tx: got %b want 1", tx_a); end
        if (tx_ready_a !== 1'b1) begin n_bad++; $display("FAIL reset_start_ignored_ready: got %b want 1", tx_ready_a); end
    endtask

    task automatic test_single();
        int t0, t1, n0;
        logic rdy_mid;
        t0 = -1; t1 = -1; rdy_mid = 1'bx;
        tick_fixed = 1'b1; clear_obs(); n0 = done_a;
        add_frame(8'hA5, DBIT_A, SB_A);
        @(posedge clk); #2;
        for (int k = 0; k < 20 && !s_tick; k++) begin @(posedge clk); #2; end
        repeat (3) @(posedge clk);
        #2; tx_start_a = 1'b1; din_a = 8'hA5;
        @(posedge clk); #2; tx_start_a = 1'b0;
        for (int k = 0; k < 4 * FLEN_A + 200; k++) begin
            @(negedge clk);
            if (t0 < 0 && tx_a === 1'b0) t0 = ph;
            if (t0 >= 0 && ph == t0 + 100) rdy_mid = tx_ready_a;
            if (tx_done_tick_a === 1'b1) begin t1 = ph; break; end
        end
        wait_done(1'b0, n0 + 1);
        n_cmp += 4;
        if (frame_diff(1'b0) != -1) begin n_bad++; $display("FAIL single_frame: first bad tick %0d want -1", frame_diff(1'b0)); end
        if (t1 - t0 != 4 * FLEN_A) begin n_bad++; $display("FAIL single_duration: got %0d clk want %0d", t1 - t0, 4 * FLEN_A); end
        if (done_a - n0 != 1) begin n_bad++; $display("FAIL single_done_count: got %0d want 1", done_a - n0); end
        if (rdy_mid !== 1'b1) begin n_bad++; $display("FAIL single_ready_mid: got %b want 1", rdy_mid); end
    endtask

    task automatic test_back_to_back();
        int n0;
        bit rose;
        logic tx_at;
        tick_fixed = 1'b0; clear_obs(); n0 = done_a; rose = 1'b0; tx_at = 1'bx;
        add_frame(8'h3C, DBIT_A, SB_A); add_frame(8'hC3, DBIT_A, SB_A);
        send_a(8'h3C);
        repeat (300) @(posedge clk);
        send_a(8'hC3);
        n_cmp++;
        if (tx_ready_a !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_after_queue: got %b want 0", tx_ready_a); end
        for (int k = 0; k < 30000; k++) begin
            @(negedge clk);
            if (tx_done_tick_a === 1'b1) begin tx_at = tx_a; break; end
            if (tx_ready_a !== 1'b0) rose = 1'b1;
        end
        wait_done(1'b0, n0 + 2);
        n_cmp += 4;
        if (rose) begin n_bad++; $display("FAIL b2b_ready_held_low: got 1 want 0"); end
        if (tx_at !== 1'b0) begin n_bad++; $display("FAIL b2b_no_gap: tx at first done got %b want 0", tx_at); end
        if (done_a - n0 != 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", done_a - n0); end
        if (frame_diff(1'b0) != -1) begin n_bad++; $display("FAIL b2b_frames: first bad tick %0d want -1", frame_diff(1'b0)); end
    endtask

    task automatic test_ignored();
        int n0;
        logic [7:0] x1, x2;
        tick_fixed = 1'b0; clear_obs(); n0 = done_a;
        x1 = 8'($urandom); x2 = 8'($urandom);
        add_frame(x1, DBIT_A, SB_A); add_frame(x2, DBIT_A, SB_A);
        send_a(x1);
        repeat (20) @(posedge clk);
        send_a(x2);
        repeat (50) @(posedge clk);
        #2; tx_start_a = 1'b1; din_a = 8'h11;
        @(posedge clk); #2; tx_start_a = 1'b0;
        wait_done(1'b0, n0 + 2);
        repeat (1500) @(negedge clk);
        n_cmp += 2;
        if (done_a - n0 != 2) begin n_bad++; $display("FAIL ignored_done_count: got %0d want 2", done_a - n0); end
        if (frame_diff(1'b0) != -1) begin n_bad++; $display("FAIL ignored_frames: first bad tick %0d want -1", frame_diff(1'b0)); end
    endtask

    task automatic test_stop_edge();
        int n0, cnt;
        bit started;
        logic [7:0] y, z;
        tick_fixed = 1'b1; clear_obs(); n0 = done_a; cnt = 0; started = 1'b0;
        y = 8'($urandom); z = 8'($urandom);
        add_frame(y, DBIT_A, SB_A); add_frame(z, DBIT_A, SB_A);
        send_a(y);
        for (int k = 0; k < 4 * FLEN_A + 200; k++) begin
            @(negedge clk);
            if (!started && tx_a === 1'b0) started = 1'b1;
            if (started && s_tick) cnt++;
            if (cnt == FLEN_A) break;
        end
        tx_start_a = 1'b1; din_a = z;
        @(posedge clk); #2; tx_start_a = 1'b0;
        n_cmp += 2;
        if (tx_done_tick_a !== 1'b1) begin n_bad++; $display("FAIL stop_edge_done: got %b want 1", tx_done_tick_a); end
        if (tx_a !== 1'b0) begin n_bad++; $display("FAIL stop_edge_start: got %b want 0", tx_a); end
        wait_done(1'b0, n0 + 2);
        n_cmp += 2;
        if (done_a - n0 != 2) begin n_bad++; $display("FAIL stop_edge_count: got %0d want 2", done_a - n0); end
        if (frame_diff(1'b0) != -1) begin n_bad++; $display("FAIL stop_edge_frames: first bad tick %0d want -1", frame_diff(1'b0)); end
    endtask

    task automatic test_hold();
        int n0, cnt, changes;
        bit started;
        logic held;
        logic [7:0] b;
        tick_fixed = 1'b1; clear_obs(); n0 = done_a; cnt = 0; changes = 0; started = 1'b0;
        b = 8'($urandom);
        add_frame(b, DBIT_A, SB_A);
        send_a(b);
        for (int k = 0; k < 2000 && cnt < 40; k++) begin
            @(negedge clk);
            if (!started && tx_a === 1'b0) started = 1'b1;
            if (started && s_tick) cnt++;
        end
        @(posedge clk); #2; tick_en = 1'b0;
        repeat (3) @(posedge clk);
        held = tx_a;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (tx_a !== held || tx_done_tick_a !== 1'b0) changes++;
        end
        #1; tick_en = 1'b1;
        wait_done(1'b0, n0 + 1);
        n_cmp += 2;
        if (changes != 0) begin n_bad++; $display("FAIL hold_static: got %0d changes want 0", changes); end
        if (frame_diff(1'b0) != -1) begin n_bad++; $display("FAIL hold_frame: first bad tick %0d want -1", frame_diff(1'b0)); end
    endtask

    task automatic test_reset_mid();
        int n0, cnt, lows;
        bit started;
        tick_fixed = 1'b0; clear_obs(); n0 = done_a; cnt = 0; lows = 0; started = 1'b0;
        send_a(8'hFF);
        send_a(8'($urandom));
        for (int k = 0; k < 4000 && cnt < 72; k++) begin
            @(negedge clk);
            if (!started && tx_a === 1'b0) started = 1'b1;
            if (started && s_tick) cnt++;
        end
        @(posedge clk); #2; reset = 1'b1;
        @(posedge clk); #2; reset = 1'b0;
        n_cmp += 3;
        if (tx_a !== 1'b1) begin n_bad++; $display("FAIL rst_mid_tx: got %b want 1", tx_a); end
        if (tx_ready_a !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", tx_ready_a); end
        if (tx_done_tick_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_done: got %b want 0", tx_done_tick_a); end
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (tx_a !== 1'b1) lows++;
        end
        n_cmp += 2;
        if (lows != 0) begin n_bad++; $display("FAIL rst_mid_no_frame: got %0d low cycles want 0", lows); end
        if (done_a != n0) begin n_bad++; $display("FAIL rst_mid_no_done: got %0d want %0d", done_a, n0); end
    endtask

    task automatic test_random();
        int n0;
        logic [7:0] b;
        tick_fixed = 1'b0; clear_obs(); n0 = done_a;
        for (int i = 0; i < 4; i++) begin
            b = (i == 0) ? 8'h07 : (i == 1) ? 8'h03 : 8'($urandom);
            add_frame(b, DBIT_A, SB_A);
            send_a(b);
        end
        wait_done(1'b0, n0 + 4);
        n_cmp += 2;
        if (done_a - n0 != 4) begin n_bad++; $display("FAIL random_done_count: got %0d want 4", done_a - n0); end
        if (frame_diff(1'b0) != -1) begin n_bad++; $display("FAIL random_frames: first bad tick %0d want -1", frame_diff(1'b0)); end
    endtask

    task automatic test_dbit7();
        int n0;
        logic [7:0] b;
        tick_fixed = 1'b0; clear_obs(); n0 = done_b;
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'hFF : 8'($urandom);
            add_frame(b, DBIT_B, SB_B);
            send_b(b);
        end
        wait_done(1'b1, n0 + 3);
        n_cmp += 3;
        if (done_b - n0 != 3) begin n_bad++; $display("FAIL dbit7_done_count: got %0d want 3", done_b - n0); end
        if (frame_diff(1'b1) != -1) begin n_bad++; $display("FAIL dbit7_frames: first bad tick %0d want -1", frame_diff(1'b1)); end
        if (tx_b !== 1'b1) begin n_bad++; $display("FAIL dbit7_idle: got %b want 1", tx_b); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignored();
        test_stop_edge();
        test_hold();
        test_reset_mid();
        test_random();
        test_dbit7();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
